xpb_seq_reducer: RTL and testbench

Sequential reduction stage that feeds and consumes the registered xpb lookup tables. It takes the high-order bits of a wide square, splits them into 5-bit segments and presents one segment per cycle to the xpb LUT bank. It adds each returned 1024-bit precomputed residue to the low-order part of the square. The resulting redundant sum (congruent to the input mod N, not fully reduced) goes to the final-reduction stage.

---
 rtl/xpb_pkg.sv | 23 ++
 rtl/xpb_wide_add.sv | 35 +++
 rtl/xpb_seq_reducer.sv | 103 ++++++++++
 tb/tb_xpb_seq_reducer.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/xpb_pkg.sv
// Shared constants and state encoding for the xpb sequential reduction stage.
package xpb_pkg;

  localparam int unsigned DATA_W  = 1024;
  localparam int unsigned SEG_W   = 5;
  localparam int unsigned NUM_SEG = 8;
  localparam int unsigned SEL_W   = 3;
  localparam int unsigned ACC_W   = 1028;
  localparam int unsigned UP_W    = NUM_SEG * SEG_W;

  typedef enum logic [1:0] {
    StIdle,
    StIssue,
    StDrain,
    StDone
  } state_e;

  // Zero-extend one LUT word to accumulator width.
  function automatic logic [ACC_W-1:0] widen(input logic [DATA_W-1:0] word);
    return {{(ACC_W - DATA_W){1'b0}}, word};
  endfunction

endpackage

// File: rtl/xpb_wide_add.sv
// Accumulator-width adder with a registered sum; load takes priority over add.
module xpb_wide_add
  import xpb_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              load,
  input  logic [ACC_W-1:0]  load_val,
  input  logic              add_en,
  input  logic [DATA_W-1:0] addend,
  output logic [ACC_W-1:0]  sum
);

  logic [ACC_W-1:0] sum_q, sum_d;

  always_comb begin
    sum_d = sum_q;
    if (load) begin
      sum_d = load_val;
    end else if (add_en) begin
      sum_d = sum_q + widen(addend);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sum_q <= '0;
    end else begin
      sum_q <= sum_d;
    end
  end

  assign sum = sum_q;

endmodule

// File: rtl/xpb_seq_reducer.sv
// Issues one upper segment per cycle to the external xpb LUT bank and accumulates
// the returned residues onto the low part of the square.
module xpb_seq_reducer
  import xpb_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [UP_W-1:0]   upper_in,
  input  logic [DATA_W-1:0] low_in,
  output logic [SEL_W-1:0]  lut_sel,
  output logic [SEG_W-1:0]  lut_idx,
  input  logic [DATA_W-1:0] lut_data,
  output logic              busy,
  output logic              done,
  output logic [ACC_W-1:0]  sum_out
);

  state_e            state_q, state_d;
  logic [SEL_W-1:0]  sel_q, sel_d;
  logic [SEG_W-1:0]  idx_q, idx_d;
  logic [UP_W-1:0]   seg_q, seg_d;
  logic              vld_q, vld_d;
  logic [ACC_W-1:0]  hold_q, hold_d;
  logic [ACC_W-1:0]  acc;
  logic              load;

  always_comb begin
    state_d = state_q;
    sel_d   = '0;
    idx_d   = '0;
    seg_d   = seg_q;
    hold_d  = hold_q;
    load    = 1'b0;
    // LUT data is valid one cycle after an issue cycle.
    vld_d   = (state_q == StIssue);
    unique case (state_q)
      StIdle: begin
        if (start) begin
          state_d = StIssue;
          load    = 1'b1;
          idx_d   = upper_in[SEG_W-1:0];
          seg_d   = upper_in >> SEG_W;
        end
      end
      StIssue: begin
        if (sel_q == SEL_W'(NUM_SEG - 1)) begin
          state_d = StDrain;
        end else begin
          sel_d = sel_q + SEL_W'(1);
          idx_d = seg_q[SEG_W-1:0];
          seg_d = seg_q >> SEG_W;
        end
      end
      StDrain: begin
        state_d = StDone;
      end
      StDone: begin
        hold_d  = acc;
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
      sel_q   <= '0;
      idx_q   <= '0;
      seg_q   <= '0;
      vld_q   <= 1'b0;
      hold_q  <= '0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      idx_q   <= idx_d;
      seg_q   <= seg_d;
      vld_q   <= vld_d;
      hold_q  <= hold_d;
    end
  end

  xpb_wide_add u_add (
    .clk      (clk),
    .reset    (reset),
    .load     (load),
    .load_val (widen(low_in)),
    .add_en   (vld_q),
    .addend   (lut_data),
    .sum      (acc)
  );

  assign lut_sel = sel_q;
  assign lut_idx = idx_q;
  assign busy    = (state_q != StIdle);
  assign done    = (state_q == StDone);
  // The final accumulator is visible in the done cycle, then held in hold_q.
  assign sum_out = done ? acc : hold_q;

endmodule

// File: tb/tb_xpb_seq_reducer.sv
// Directed bench for xpb_seq_reducer with a cycle-level reference model and LUT model.
module tb_xpb_seq_reducer;
  import xpb_pkg::*;

  logic              clk = 1'b0;
  logic              reset;
  logic              start;
  logic [UP_W-1:0]   upper_in;
  logic [DATA_W-1:0] low_in;
  logic [SEL_W-1:0]  lut_sel;
  logic [SEG_W-1:0]  lut_idx;
  logic [DATA_W-1:0] lut_data = '0;
  logic              busy;
  logic              done;
  logic [ACC_W-1:0]  sum_out;

  int n_checks = 0;
  int n_fail   = 0;
  logic chk_en = 1'b0;
  logic max_mode = 1'b0;

  xpb_seq_reducer dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .upper_in (upper_in),
    .low_in   (low_in),
    .lut_sel  (lut_sel),
    .lut_idx  (lut_idx),
    .lut_data (lut_data),
    .busy     (busy),
    .done     (done),
    .sum_out  (sum_out)
  );

  always #5 clk = ~clk;

  function automatic logic [DATA_W-1:0] lut_f(input logic [SEL_W-1:0] sel,
                                              input logic [SEG_W-1:0] idx);
    int unsigned v;
    if (max_mode) return (idx != 0) ? '1 : '0;
    v = (32'(sel) + 1) * 32'(idx);
    return DATA_W'(v);
  endfunction

  function automatic logic [ACC_W-1:0] calc(input logic [UP_W-1:0] up,
                                            input logic [DATA_W-1:0] low);
    logic [ACC_W-1:0] s;
    s = ACC_W'(low);
    for (int k = 0; k < NUM_SEG; k++) s = s + ACC_W'(lut_f(SEL_W'(k), up[k*SEG_W +: SEG_W]));
    return s;
  endfunction

  task automatic check(input string name, input logic [ACC_W-1:0] got,
                       input logic [ACC_W-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got hi=%h lo=%h, expected hi=%h lo=%h", name,
               got[ACC_W-1:ACC_W-36], got[95:0], exp[ACC_W-1:ACC_W-36], exp[95:0]);
    end
  endtask

  // LUT model and operation-level reference model
  logic             m_active = 1'b0;
  int               m_c = 0;
  logic [UP_W-1:0]  m_up = '0;
  logic [ACC_W-1:0] m_result = '0;
  logic [ACC_W-1:0] m_sum = '0;

  always @(posedge clk) begin
    lut_data <= lut_f(lut_sel, lut_idx);
    if (reset) begin
      m_active <= 1'b0;
      m_c      <= 0;
      m_sum    <= '0;
    end else if (!m_active) begin
      if (start) begin
        m_active <= 1'b1;
        m_c      <= 1;
        m_up     <= upper_in;
        m_result <= calc(upper_in, low_in);
      end
    end else begin
      if (m_c == NUM_SEG + 1) m_sum <= m_result;
      if (m_c == NUM_SEG + 2) begin
        m_active <= 1'b0;
        m_c      <= 0;
      end else begin
        m_c <= m_c + 1;
      end
    end
  end

  task automatic compare_cycle();
    logic             issuing;
    logic [SEL_W-1:0] e_sel;
    logic [SEG_W-1:0] e_idx;
    issuing = m_active && (m_c >= 1) && (m_c <= NUM_SEG);
    e_sel = issuing ? SEL_W'(m_c - 1) : '0;
    e_idx = issuing ? m_up[(m_c-1)*SEG_W +: SEG_W] : '0;
    check("busy", ACC_W'(busy), ACC_W'(m_active));
    check("done", ACC_W'(done), ACC_W'(m_active && (m_c == NUM_SEG + 2)));
    check("lut_sel", ACC_W'(lut_sel), ACC_W'(e_sel));
    check("lut_idx", ACC_W'(lut_idx), ACC_W'(e_idx));
    check("sum_out", sum_out, m_sum);
  endtask

  task automatic run_op(input string name, input logic [UP_W-1:0] up,
                        input logic [DATA_W-1:0] low, input logic [ACC_W-1:0] exp);
    int n;
    @(negedge clk);
    start = 1'b1; upper_in = up; low_in = low;
    @(negedge clk);
    start = 1'b0;
    n = 1;
    while (!done && n < 40) begin
      @(negedge clk);
      n++;
    end
    check({name, "_latency"}, ACC_W'(n), ACC_W'(10));
    check({name, "_sum"}, sum_out, exp);
  endtask

  logic [ACC_W-1:0] all1;
  int dones, dcyc, n;

  initial begin
    reset = 1'b1; start = 1'b0; upper_in = '0; low_in = '0;
    all1 = ACC_W'({DATA_W{1'b1}});
    fork
      forever begin
        @(negedge clk);
        if (chk_en) compare_cycle();
      end
    join_none
    @(negedge clk);
    chk_en = 1'b1;
    @(negedge clk);
    check("rst_busy", ACC_W'(busy), '0);
    check("rst_done", ACC_W'(done), '0);
    check("rst_sum", sum_out, '0);
    check("rst_sel_idx", ACC_W'({lut_sel, lut_idx}), '0);
    reset = 1'b0;

    run_op("zero_upper", '0, DATA_W'(5), ACC_W'(5));
    run_op("ramp", {5'd8, 5'd7, 5'd6, 5'd5, 5'd4, 5'd3, 5'd2, 5'd1}, '0, ACC_W'(204));
    max_mode = 1'b1;
    run_op("max", {NUM_SEG{5'd31}}, '1, all1 * ACC_W'(9));
    @(negedge clk);
    max_mode = 1'b0;

    // Starts during an operation and in its done cycle are ignored.
    @(negedge clk);
    start = 1'b1; upper_in = {NUM_SEG{5'd3}}; low_in = DATA_W'(100);
    dones = 0; dcyc = 0;
    for (int c = 1; c <= 10; c++) begin
      @(negedge clk);
      if (c == 1) start = 1'b0;
      if (c == 3) begin start = 1'b1; upper_in = '0; low_in = '0; end
      if (c == 4) start = 1'b0;
      if (done) begin dones++; dcyc = c; end
      if (c == 10) begin
        check("ign_sum", sum_out, ACC_W'(208));
        start = 1'b1; upper_in = UP_W'(5'd31); low_in = DATA_W'(7);
      end
    end
    check("ign_done_count", ACC_W'(dones), ACC_W'(1));
    check("ign_done_cycle", ACC_W'(dcyc), ACC_W'(10));
    @(negedge clk);
    check("idle_c11", ACC_W'(busy), '0);
    @(negedge clk);
    start = 1'b0;
    n = 12;
    while (!done && n < 40) begin
      @(negedge clk);
      n++;
    end
    check("b2b_done_cycle", ACC_W'(n), ACC_W'(21));
    check("b2b_sum", sum_out, ACC_W'(38));

    // Reset in the middle of an operation aborts it.
    @(negedge clk);
    @(negedge clk);
    start = 1'b1; upper_in = {NUM_SEG{5'd1}}; low_in = DATA_W'(1);
    for (int c = 1; c <= 5; c++) begin
      @(negedge clk);
      if (c == 1) start = 1'b0;
    end
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("abort_busy", ACC_W'(busy), '0);
    check("abort_sum", sum_out, '0);
    check("abort_idx", ACC_W'(lut_idx), '0);
    dones = 0;
    for (int c = 0; c < 12; c++) begin
      if (done) dones++;
      @(negedge clk);
    end
    check("abort_no_done", ACC_W'(dones), '0);
    run_op("after_abort", {5'd2, 35'd0}, DATA_W'(10), ACC_W'(26));

    repeat (3) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
